// File: rtl/inst_queue_if.sv
// Fetch-to-decode handshake bundle for inst_queue: two fetch slots in, two packed
// decode words out. master = IF/ID side, slave = the queue.
interface inst_queue_if;
   logic [1:0]   in_valid;
   logic         in_ready;
   logic [31:0]  in_inst0, in_inst1;
   logic [31:0]  in_pc0, in_pc1;
   logic [31:0]  in_pc_next0, in_pc_next1;
   logic [6:0]   in_exception0, in_exception1;
   logic [31:0]  in_badv0, in_badv1;
   logic         in_unknown0, in_unknown1;
   logic [136:0] out_word0, out_word1;
   logic [1:0]   out_ack;

   modport master (
      output in_valid, in_inst0, in_inst1, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
             in_exception0, in_exception1, in_badv0, in_badv1, in_unknown0, in_unknown1,
             out_ack,
      input  in_ready, out_word0, out_word1
   );

   modport slave (
      input  in_valid, in_inst0, in_inst1, in_pc0, in_pc1, in_pc_next0, in_pc_next1,
             in_exception0, in_exception1, in_badv0, in_badv1, in_unknown0, in_unknown1,
             out_ack,
      output in_ready, out_word0, out_word1
   );
endinterface

// File: rtl/inst_queue.sv
// Dual-issue fetch-to-decode instruction queue (circular buffer, two in / two out).
// Optional same-cycle bypass on an empty queue: define INST_QUEUE_BYPASS_EN.
module inst_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input logic        clk,
   input logic        rst,
   input logic        flush,
   inst_queue_if.slave q
);
   localparam int ENT_W = 136;

   logic [ENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;
   logic [ENT_W-1:0] slot0, slot1, wr0;
   logic [1:0]       push_n, ack_n, pop_n, bp_n, store_n;

   function automatic logic [ENT_W-1:0] pack_entry(
      input logic        unknown,
      input logic [31:0] badv,
      input logic [6:0]  exc,
      input logic [31:0] pc_next,
      input logic [31:0] pc,
      input logic [31:0] inst
   );
      return {unknown, badv, exc, pc_next, pc, inst};
   endfunction

   assign slot0 = pack_entry(q.in_unknown0, q.in_badv0, q.in_exception0,
                             q.in_pc_next0, q.in_pc0, q.in_inst0);
   assign slot1 = pack_entry(q.in_unknown1, q.in_badv1, q.in_exception1,
                             q.in_pc_next1, q.in_pc1, q.in_inst1);

   // Ready looks only at registered occupancy so IF never sees a path from decode acks.
   assign q.in_ready = (count <= (PTR_W+1)'(DEPTH-2));

   always_comb begin
      push_n = 2'd0;
      if (q.in_ready && !flush && q.in_valid[0])
         push_n = (q.in_valid[1] && (q.in_exception0 == 7'd0)) ? 2'd2 : 2'd1;
      ack_n = q.out_ack[0] ? (q.out_ack[1] ? 2'd2 : 2'd1) : 2'd0;
      if ((PTR_W+1)'(ack_n) > count)
         pop_n = count[1:0];
      else
         pop_n = ack_n;
   end

`ifdef INST_QUEUE_BYPASS_EN
   // Entries consumed straight off the fetch bus while empty never touch storage.
   always_comb begin
      bp_n = 2'd0;
      if (count == 0)
         bp_n = (ack_n < push_n) ? ack_n : push_n;
   end
   assign wr0 = (bp_n == 2'd0) ? slot0 : slot1;
`else
   assign bp_n = 2'd0;
   assign wr0  = slot0;
`endif

   assign store_n = push_n - bp_n;

   always_comb begin
      q.out_word0 = '0;
      q.out_word1 = '0;
      if (count != 0)
         q.out_word0 = {1'b1, mem[head]};
      if (count > 1)
         q.out_word1 = {1'b1, mem[head + PTR_W'(1)]};
`ifdef INST_QUEUE_BYPASS_EN
      if (count == 0 && push_n != 2'd0)
         q.out_word0 = {1'b1, slot0};
      if (count == 0 && push_n == 2'd2)
         q.out_word1 = {1'b1, slot1};
`endif
   end

   // Entry storage is left unreset; occupancy masks stale contents.
   always_ff @(posedge clk) begin
      if (store_n != 2'd0)
         mem[tail] <= wr0;
      if (store_n == 2'd2)
         mem[tail + PTR_W'(1)] <= slot1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(store_n);
         count <= count + (PTR_W+1)'(store_n) - (PTR_W+1)'(pop_n);
      end
   end
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue (default build, no bypass): accepted entries are
// queued as expected decode words and retired as decode acknowledges them.
module tb_inst_queue;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [136:0] exp_q[$];

   inst_queue_if qi();

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .q     (qi)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [136:0] got, input logic [136:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [136:0] word0_in();
      return {1'b1, qi.in_unknown0, qi.in_badv0, qi.in_exception0,
              qi.in_pc_next0, qi.in_pc0, qi.in_inst0};
   endfunction

   function automatic logic [136:0] word1_in();
      return {1'b1, qi.in_unknown1, qi.in_badv1, qi.in_exception1,
              qi.in_pc_next1, qi.in_pc1, qi.in_inst1};
   endfunction

   task automatic rand_fields();
      qi.in_inst0 = $urandom; qi.in_inst1 = $urandom;
      qi.in_pc0 = $urandom; qi.in_pc1 = $urandom;
      qi.in_pc_next0 = $urandom; qi.in_pc_next1 = $urandom;
      qi.in_badv0 = $urandom; qi.in_badv1 = $urandom;
      qi.in_unknown0 = 1'($urandom); qi.in_unknown1 = 1'($urandom);
      qi.in_exception0 = 7'd0;
      qi.in_exception1 = 7'($urandom);
   endtask

   // Entered just after a rising edge; drives, checks state mid-cycle, then models the edge.
   task automatic step(input logic [1:0] vld, input logic [1:0] ack, input bit fl, input bit rnd);
      logic         exp_ready;
      logic [136:0] e0, e1;
      int           npop;
      if (rnd) rand_fields();
      qi.in_valid = vld;
      qi.out_ack  = ack;
      flush       = fl;
      #4;
      exp_ready = (exp_q.size() <= DEPTH-2);
      e0 = (exp_q.size() > 0) ? exp_q[0] : '0;
      e1 = (exp_q.size() > 1) ? exp_q[1] : '0;
      check("in_ready", {136'd0, qi.in_ready}, {136'd0, exp_ready});
      check("out_word0", qi.out_word0, e0);
      check("out_word1", qi.out_word1, e1);
      if (fl) begin
         exp_q.delete();
      end else begin
         npop = ack[0] ? (ack[1] ? 2 : 1) : 0;
         if (npop > exp_q.size()) npop = exp_q.size();
         repeat (npop) void'(exp_q.pop_front());
         if (exp_ready && vld[0]) begin
            exp_q.push_back(word0_in());
            if (vld[1] && qi.in_exception0 == 7'd0)
               exp_q.push_back(word1_in());
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rand_fields();
      qi.in_valid = 2'b00;
      qi.out_ack  = 2'b00;
      #12 rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset state
      check("rst_ready", {136'd0, qi.in_ready}, 137'd1);
      check("rst_word0", qi.out_word0, '0);
      step(2'b00, 2'b00, 1'b0, 1'b1);

      // Packing of a single entry
      qi.in_inst0 = 32'h02800c21; qi.in_pc0 = 32'h1c000000; qi.in_pc_next0 = 32'h1c000004;
      qi.in_exception0 = 7'h00; qi.in_badv0 = 32'h0; qi.in_unknown0 = 1'b0;
      step(2'b01, 2'b00, 1'b0, 1'b0);
      check("pack_word0", qi.out_word0,
            {1'b1, 1'b0, 32'h0, 7'h0, 32'h1c000004, 32'h1c000000, 32'h02800c21});
      check("pack_word1", qi.out_word1, '0);
      step(2'b00, 2'b01, 1'b0, 1'b1);

      // Exception cut drops slot1
      rand_fields();
      qi.in_exception0 = 7'h08; qi.in_badv0 = 32'h1c000002;
      step(2'b11, 2'b00, 1'b0, 1'b0);
      check("exc_code", {130'd0, qi.out_word0[102:96]}, 137'h08);
      check("exc_badv", {105'd0, qi.out_word0[134:103]}, 137'h1c000002);
      check("exc_word1", qi.out_word1, '0);
      step(2'b10, 2'b01, 1'b0, 1'b1);

      // Fill to 7 then 8-full attempts, then drain in pairs; twice so pointers wrap
      for (int r = 0; r < 2; r++) begin
         step(2'b01, 2'b00, 1'b0, 1'b1);
         for (int i = 0; i < 4; i++) step(2'b11, 2'b00, 1'b0, 1'b1);
         step(2'b11, 2'b00, 1'b0, 1'b1);
         for (int i = 0; i < 5; i++) step(2'b11, 2'b11, 1'b0, 1'b1);
      end
      step(2'b11, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(2'b11, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(2'b00, 2'b11, 1'b0, 1'b1);

      // Simultaneous push and pop at count=3, then over-ack at count=1
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b01, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b11, 1'b0, 1'b1);
      step(2'b00, 2'b11, 1'b0, 1'b1);
      step(2'b00, 2'b01, 1'b0, 1'b1);
      step(2'b01, 2'b00, 1'b0, 1'b1);
      step(2'b00, 2'b11, 1'b0, 1'b1);
      step(2'b00, 2'b00, 1'b0, 1'b1);

      // Flush at count=4 with push and ack pending
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b01, 1'b1, 1'b1);
      check("flush_word0", qi.out_word0, '0);
      check("flush_word1", qi.out_word1, '0);
      step(2'b00, 2'b00, 1'b0, 1'b1);

      // Async reset mid-stream at count=5
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b01, 2'b00, 1'b0, 1'b1);
      qi.in_valid = 2'b00;
      qi.out_ack  = 2'b00;
      #1 rst = 1'b1;
      #1;
      check("arst_word0", qi.out_word0, '0);
      check("arst_word1", qi.out_word1, '0);
      check("arst_ready", {136'd0, qi.in_ready}, 137'd1);
      exp_q.delete();
      @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      step(2'b11, 2'b00, 1'b0, 1'b1);
      step(2'b00, 2'b11, 1'b0, 1'b1);
      step(2'b00, 2'b00, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Fetch-to-decode instruction queue: accepts up to two fetched instructions per cycle from the IF stage.
- Stores each entry and presents the two oldest entries as packed 137-bit words, one to each of the two decoders.
- Packed word layout: {nempty, unknown, badv, exception, pc_next, pc, inst}.
- Absorbs IF/ID rate mismatch and is cleared on pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, ≥4.
- PTR_W, $clog2(DEPTH), pointer width; count register is PTR_W+1 bits.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  discard all entries and same-cycle inputs
- in_valid  input  2  per-slot valid from IF; bit1 only legal with bit0
- in_ready  output  1  queue can take two entries this cycle
- in_inst0, in_inst1  input  32 each  instruction words
- in_pc0, in_pc1  input  32 each  instruction PCs
- in_pc_next0, in_pc_next1  input  32 each  predicted next PCs
- in_exception0, in_exception1  input  7 each  IF exception code, 0 = none
- in_badv0, in_badv1  input  32 each  faulting virtual address
- in_unknown0, in_unknown1  input  1 each  fetch result unknown/speculative marker
- out_word0, out_word1  output  137 each  packed entries, oldest in word0
- out_ack  input  2  decode consumed word0 / word0+word1; bit1 only legal with bit0

Behaviour:
- Packing, bit positions:
  - [136] nempty = 1 for a valid entry.
  - [135] unknown, [134:103] badv, [102:96] exception.
  - [95:64] pc_next, [63:32] pc, [31:0] inst.
- An empty output slot drives all 137 bits to 0.
- Storage: circular buffer with head, tail and count registers. Pointers wrap modulo DEPTH.
- in_ready = (count ≤ DEPTH-2), evaluated on registered count only; it does not depend on same-cycle out_ack.
- Enqueue: on a rising clk edge with in_ready=1 and no flush:
  - in_valid=01 writes slot0 at tail.
  - in_valid=11 writes slot0 at tail and slot1 at tail+1.
  - in_valid=10 is treated as 00.
- Exception cut: if in_valid[0]=1 and in_exception0≠0, slot1 is dropped. Only one entry is enqueued.
- in_valid while in_ready=0 is ignored; IF must hold and retry.
- Dequeue: out_ack=01 pops 1 entry; out_ack=11 pops 2; 10 is treated as 00.
- Acks beyond occupancy are clamped: popped = min(ack count, count).
- Same-cycle enqueue and dequeue are both applied. count_next = count + pushed − popped.
- Output words are combinational reads of entry[head] and entry[head+1], gated by count>0 and count>1 respectively.
- Flush has priority over all pushes and pops: head=tail=count=0 at the next edge. Outputs read 0 from the following cycle.
- Reset (async, mid-operation included): head=tail=count=0. out_word0=out_word1=0, in_ready=1.
- Entry contents are not reset; they are masked by count.
- Full (count=DEPTH) and count=DEPTH-1 both force in_ready=0.
- Minimum latency, input to output, is 1 cycle.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- When defined and count=0, valid inputs appear on out_word0/out_word1 in the same cycle. Acked bypassed entries are not written. Unacked entries are written normally.
- flush suppresses the bypass path.
- When undefined, no combinational path exists from any in_* input to any out_* output, and latency is exactly 1 cycle.

Test Plan:
- Reset: assert rst mid-stream with count=5 -> out_word0=out_word1=0 and in_ready=1 immediately (async); count=0 after release.
- Pack check: push in_inst0=32'h02800c21, pc=32'h1c000000, pc_next=32'h1c000004, exc=0, badv=0, unknown=0 -> next cycle out_word0 = {1'b1,1'b0,32'h0,7'h0,32'h1c000004,32'h1c000000,32'h02800c21}; out_word1=0.
- Exception cut: in_valid=11, in_exception0=7'h08, badv0=32'h1c000002 -> exactly one entry; out_word0[102:96]=7'h08, [134:103]=32'h1c000002; out_word1=0.
- Fill: DEPTH=8, push pairs with out_ack=00 -> in_ready falls once count=7 or 8; further in_valid ignored; drain with out_ack=11 returns entries in push order, pointers wrap correctly.
- Simultaneous: count=3, push 2 and ack 11 in one cycle -> count=3, head advanced by 2; out_ack=11 at count=1 pops only 1.
- Flush: flush=1 with in_valid=11 and out_ack=01 at count=4 -> next cycle count=0, both out_words=0, nothing enqueued.
